timer_digitos: RTL and testbench

TIMER_DIGITOS -- requirements
Module: timer_digitos

---
 rtl/timer_digitos_pkg.sv | 18 +
 rtl/timer_digitos_bcd_dec_digit.sv | 26 ++
 rtl/timer_digitos.sv | 123 ++++++++++++
 tb/tb_timer_digitos.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_digitos_pkg.sv
// rtl/timer_digitos_pkg.sv - shared state encoding, BCD constants and digit type
package timer_digitos_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOADING  = 3'd1,
    COUNTING = 3'd2,
    PAUSED   = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam digit_t BCD_ZERO    = 4'd0;
  localparam digit_t BCD_NOVE    = 4'd9;
  localparam digit_t SEG_DEZ_MAX = 4'd5;

endpackage

// File: rtl/timer_digitos_bcd_dec_digit.sv
// rtl/timer_digitos_bcd_dec_digit.sv - one-digit BCD decrement with wrap value and borrow chain
module bcd_dec_digit
  import timer_digitos_pkg::*;
#(
  parameter digit_t WRAP = BCD_NOVE
) (
  input  digit_t d,
  input  logic   borrow_in,
  output digit_t q,
  output logic   borrow_out
);

  always_comb begin
    q          = d;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (d == BCD_ZERO) begin
        q          = WRAP;
        borrow_out = 1'b1;
      end else begin
        q = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/timer_digitos.sv
// rtl/timer_digitos.sv - MM:SS keypad-loaded countdown timer; SEG_CLAMP_EN clamps seconds tens to 5 on start
module timer_digitos
  import timer_digitos_pkg::*;
(
  input  logic       Hz_100_clock,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] min_dez,
  output logic [3:0] min_uni,
  output logic [3:0] seg_dez,
  output logic [3:0] seg_uni,
  output logic       enablen,
  output logic       magnetron_on,
  output logic       done
);

  state_t state, state_nx;
  logic   sync1, sync2, prev, tick;
  digit_t md_nx, mu_nx, sd_nx, su_nx;
  digit_t md_dec, mu_dec, sd_dec, su_dec;
  digit_t sd_start;
  logic   b_su, b_sd, b_mu, time_zero;
  logic   dec_zero;

  assign tick = sync2 & ~prev;

  // Borrow rippling out of the top digit means the current time is 00:00.
  bcd_dec_digit #(.WRAP(BCD_NOVE))    u_seg_uni (.d(seg_uni), .borrow_in(1'b1), .q(su_dec), .borrow_out(b_su));
  bcd_dec_digit #(.WRAP(SEG_DEZ_MAX)) u_seg_dez (.d(seg_dez), .borrow_in(b_su), .q(sd_dec), .borrow_out(b_sd));
  bcd_dec_digit #(.WRAP(BCD_NOVE))    u_min_uni (.d(min_uni), .borrow_in(b_sd), .q(mu_dec), .borrow_out(b_mu));
  bcd_dec_digit #(.WRAP(BCD_NOVE))    u_min_dez (.d(min_dez), .borrow_in(b_mu), .q(md_dec), .borrow_out(time_zero));

  assign dec_zero = (md_dec == BCD_ZERO) && (mu_dec == BCD_ZERO) &&
                    (sd_dec == BCD_ZERO) && (su_dec == BCD_ZERO);

`ifdef SEG_CLAMP_EN
  assign sd_start = (seg_dez > SEG_DEZ_MAX) ? SEG_DEZ_MAX : seg_dez;
`else
  assign sd_start = seg_dez;
`endif

  always_comb begin
    state_nx = state;
    md_nx    = min_dez;
    mu_nx    = min_uni;
    sd_nx    = seg_dez;
    su_nx    = seg_uni;
    case (state)
      IDLE, LOADING: begin
        if (stop) begin
          state_nx = IDLE;
          md_nx = BCD_ZERO; mu_nx = BCD_ZERO; sd_nx = BCD_ZERO; su_nx = BCD_ZERO;
        end else if (start) begin
          // A start always swallows a coincident digit, even when it is ignored.
          if (!time_zero) begin
            state_nx = COUNTING;
            sd_nx    = sd_start;
          end
        end else if (tick && !loadn && (D <= BCD_NOVE)) begin
          state_nx = LOADING;
          md_nx = min_uni; mu_nx = seg_dez; sd_nx = seg_uni; su_nx = D;
        end
      end
      COUNTING: begin
        if (stop) begin
          state_nx = PAUSED;
        end else if (tick && !time_zero) begin
          md_nx = md_dec; mu_nx = mu_dec; sd_nx = sd_dec; su_nx = su_dec;
          if (dec_zero) state_nx = DONE;
        end
      end
      PAUSED: begin
        if (stop) begin
          state_nx = IDLE;
          md_nx = BCD_ZERO; mu_nx = BCD_ZERO; sd_nx = BCD_ZERO; su_nx = BCD_ZERO;
        end else if (start && !time_zero) begin
          state_nx = COUNTING;
          sd_nx    = sd_start;
        end
      end
      DONE: begin
        if (stop) begin
          state_nx = IDLE;
          md_nx = BCD_ZERO; mu_nx = BCD_ZERO; sd_nx = BCD_ZERO; su_nx = BCD_ZERO;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Hz_100_clock) begin
    if (clear) begin
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prev         <= 1'b0;
      state        <= IDLE;
      min_dez      <= BCD_ZERO;
      min_uni      <= BCD_ZERO;
      seg_dez      <= BCD_ZERO;
      seg_uni      <= BCD_ZERO;
      enablen      <= 1'b0;
      magnetron_on <= 1'b0;
      done         <= 1'b0;
    end else begin
      sync1        <= pgt_1Hz;
      sync2        <= sync1;
      prev         <= sync2;
      state        <= state_nx;
      min_dez      <= md_nx;
      min_uni      <= mu_nx;
      seg_dez      <= sd_nx;
      seg_uni      <= su_nx;
      enablen      <= !((state_nx == IDLE) || (state_nx == LOADING));
      magnetron_on <= (state_nx == COUNTING);
      done         <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_timer_digitos.sv
// tb/tb_timer_digitos.sv - directed and randomized checks of timer_digitos against a time-arithmetic model
module tb_timer_digitos;
  import timer_digitos_pkg::*;

  logic       clk = 1'b0;
  logic       clear, loadn, pgt_1Hz, start, stop;
  logic [3:0] D;
  logic [3:0] min_dez, min_uni, seg_dez, seg_uni;
  logic       enablen, magnetron_on, done;

  int     n_assert = 0;
  int     n_fail   = 0;
  int     m[4];
  state_t ms;

  timer_digitos dut (
    .Hz_100_clock(clk), .clear(clear), .D(D), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .start(start), .stop(stop), .min_dez(min_dez), .min_uni(min_uni),
    .seg_dez(seg_dez), .seg_uni(seg_uni), .enablen(enablen),
    .magnetron_on(magnetron_on), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic bit model_zero();
    return (m[0] + m[1] + m[2] + m[3]) == 0;
  endfunction

  task automatic model_clear_digits();
    for (int i = 0; i < 4; i++) m[i] = 0;
  endtask

  task automatic model_start();
    if (!model_zero()) begin
`ifdef SEG_CLAMP_EN
      if (m[2] > 5) m[2] = 5;
`endif
      ms = COUNTING;
    end
  endtask

  // Countdown done on whole minutes/seconds values, not digit by digit.
  task automatic model_dec();
    int mm, ss;
    mm = m[0] * 10 + m[1];
    ss = m[2] * 10 + m[3];
    if (ss == 0) begin
      ss = 59;
      mm = mm - 1;
    end else begin
      ss = ss - 1;
    end
    m[0] = mm / 10; m[1] = mm % 10; m[2] = ss / 10; m[3] = ss % 10;
  endtask

  task automatic model_cycle(input bit tk, input bit st, input bit sp, input bit ln, input int d);
    case (ms)
      IDLE, LOADING: begin
        if (sp) begin model_clear_digits(); ms = IDLE; end
        else if (st) model_start();
        else if (tk && !ln && d <= 9) begin
          m[0] = m[1]; m[1] = m[2]; m[2] = m[3]; m[3] = d;
          ms = LOADING;
        end
      end
      COUNTING: begin
        if (sp) ms = PAUSED;
        else if (tk && !model_zero()) begin
          model_dec();
          if (model_zero()) ms = DONE;
        end
      end
      PAUSED: begin
        if (sp) begin model_clear_digits(); ms = IDLE; end
        else if (st) model_start();
      end
      default: begin
        if (sp) begin model_clear_digits(); ms = IDLE; end
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".min_dez"}, {4'd0, min_dez}, 8'(m[0]));
    chk({tag, ".min_uni"}, {4'd0, min_uni}, 8'(m[1]));
    chk({tag, ".seg_dez"}, {4'd0, seg_dez}, 8'(m[2]));
    chk({tag, ".seg_uni"}, {4'd0, seg_uni}, 8'(m[3]));
    chk({tag, ".state"}, {5'd0, dut.state}, {5'd0, ms});
    chk({tag, ".enablen"}, {7'd0, enablen}, {7'd0, !(ms == IDLE || ms == LOADING)});
    chk({tag, ".magnetron_on"}, {7'd0, magnetron_on}, {7'd0, ms == COUNTING});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, ms == DONE});
  endtask

  task automatic expect_time(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, ".mmss"}, {min_dez, min_uni}, 8'(a * 16 + b));
    chk({tag, ".ss"}, {seg_dez, seg_uni}, 8'(c * 16 + d));
  endtask

  // Tick reaches the FSM on the third edge after pgt_1Hz rises; start/stop ride that edge.
  task automatic do_tick(input logic [3:0] d, input bit ln, input bit st, input bit sp);
    D = d; loadn = ln; pgt_1Hz = 1'b1;
    step();
    step();
    start = st; stop = sp;
    step();
    model_cycle(1'b1, st, sp, ln, int'(d));
    start = 1'b0; stop = 1'b0; pgt_1Hz = 1'b0;
    step();
    step();
    loadn = 1'b1;
  endtask

  task automatic cmd(input bit st, input bit sp);
    start = st; stop = sp;
    step();
    model_cycle(1'b0, st, sp, 1'b1, 0);
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic load4(input int a, input int b, input int c, input int d);
    do_tick(4'(a), 1'b0, 1'b0, 1'b0);
    do_tick(4'(b), 1'b0, 1'b0, 1'b0);
    do_tick(4'(c), 1'b0, 1'b0, 1'b0);
    do_tick(4'(d), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    clear = 1'b1; loadn = 1'b1; pgt_1Hz = 1'b0; start = 1'b0; stop = 1'b0; D = 4'd0;
    ms = IDLE;
    model_clear_digits();
    step();
    step();
    check_all("reset");
    clear = 1'b0;

    load4(1, 2, 3, 0);
    check_all("load_1230");
    expect_time("load_1230", 1, 2, 3, 0);
    cmd(1'b0, 1'b1);
    check_all("stop_idle");

    load4(0, 0, 0, 2);
    cmd(1'b1, 1'b0);
    check_all("start_2s");
    do_tick(4'd0, 1'b1, 1'b0, 1'b0);
    expect_time("cnt_0001", 0, 0, 0, 1);
    do_tick(4'd0, 1'b1, 1'b0, 1'b0);
    check_all("cnt_done");
    chk("done_flag", {7'd0, done}, 8'd1);
    cmd(1'b1, 1'b0);
    do_tick(4'd3, 1'b0, 1'b0, 1'b0);
    check_all("done_ignores");
    cmd(1'b0, 1'b1);
    check_all("done_stop");

    load4(0, 1, 0, 0);
    cmd(1'b1, 1'b0);
    do_tick(4'd0, 1'b1, 1'b0, 1'b0);
    expect_time("min_borrow", 0, 0, 5, 9);
    cmd(1'b0, 1'b1);
    do_tick(4'd0, 1'b1, 1'b0, 1'b0);
    check_all("paused_hold");
    cmd(1'b0, 1'b1);
    check_all("paused_stop");

    load4(0, 0, 9, 9);
    cmd(1'b1, 1'b0);
`ifdef SEG_CLAMP_EN
    expect_time("clamp", 0, 0, 5, 9);
`else
    do_tick(4'd0, 1'b1, 1'b0, 1'b0);
    expect_time("no_clamp", 0, 0, 9, 8);
`endif
    check_all("s99");
    cmd(1'b0, 1'b1);
    cmd(1'b0, 1'b1);

    cmd(1'b1, 1'b0);
    check_all("start_zero");
    load4(0, 0, 0, 5);
    cmd(1'b1, 1'b0);
    cmd(1'b1, 1'b1);
    check_all("start_stop_same");
    cmd(1'b0, 1'b1);

    load4(0, 0, 0, 3);
    do_tick(4'd7, 1'b0, 1'b1, 1'b0);
    check_all("start_beats_digit");
    expect_time("start_beats_digit", 0, 0, 0, 3);
    cmd(1'b0, 1'b1);
    cmd(1'b0, 1'b1);

    load4(1, 2, 3, 4);
    do_tick(4'd5, 1'b0, 1'b0, 1'b0);
    do_tick(4'd12, 1'b0, 1'b0, 1'b0);
    check_all("fifth_digit");
    expect_time("fifth_digit", 2, 3, 4, 5);
    cmd(1'b0, 1'b1);

    load4(0, 5, 1, 8);
    cmd(1'b1, 1'b0);
    do_tick(4'd0, 1'b1, 1'b0, 1'b0);
    expect_time("pre_clear", 0, 5, 1, 7);
    clear = 1'b1;
    step();
    clear = 1'b0;
    ms = IDLE;
    model_clear_digits();
    check_all("clear_mid");
    chk("clear_sync", {6'd0, dut.sync2, dut.prev}, 8'd0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7)
        do_tick(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0));
      else
        cmd(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      check_all("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
